// File: rtl/audio_playback_serializer.sv
// audio_playback_serializer: reads 16-bit sample words from block RAM
// (address 0 up to a latched last address) and shifts each word out
// MSB-first on audio_out, one bit every CLK_DIV clocks, with the next
// word prefetched so that consecutive words follow without gaps.
module audio_playback_serializer #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CLK_DIV    = 50
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  play,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ena,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  audio_out,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_WAIT,
        ST_RUN
    } state_t;

    state_t                state, state_n;
    logic                  play_q;
    logic [ADDR_WIDTH-1:0] word_addr, word_addr_n;
    logic [ADDR_WIDTH-1:0] end_addr, end_addr_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic [DATA_WIDTH-1:0] hold, hold_n;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_n;
    logic [DIV_W-1:0]      div_cnt, div_cnt_n;
    logic                  mem_ena_n;
    logic [ADDR_WIDTH-1:0] mem_addr_n;
    logic                  audio_out_n;
    logic                  busy_n;
    logic                  done_n;

    // Edge-detect history for play; tracks play through reset so a level
    // already high at reset release is not mistaken for a start.
    always_ff @(posedge clock) begin
        play_q <= play;
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            word_addr <= '0;
            end_addr  <= '0;
            shift     <= '0;
            hold      <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            mem_ena   <= 1'b0;
            mem_addr  <= '0;
            audio_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            word_addr <= word_addr_n;
            end_addr  <= end_addr_n;
            shift     <= shift_n;
            hold      <= hold_n;
            bit_cnt   <= bit_cnt_n;
            div_cnt   <= div_cnt_n;
            mem_ena   <= mem_ena_n;
            mem_addr  <= mem_addr_n;
            audio_out <= audio_out_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_n     = state;
        word_addr_n = word_addr;
        end_addr_n  = end_addr;
        shift_n     = shift;
        hold_n      = hold;
        bit_cnt_n   = bit_cnt;
        div_cnt_n   = div_cnt;
        done_n      = 1'b0;
        mem_ena_n   = 1'b0;
        mem_addr_n  = mem_addr;
        audio_out_n = 1'b0;
        busy_n      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (play && !play_q) begin
                    end_addr_n  = last_addr;
                    word_addr_n = '0;
                    state_n     = ST_PRIME;
                end
            end
            ST_PRIME: begin
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                shift_n   = mem_data;
                bit_cnt_n = '0;
                div_cnt_n = '0;
                state_n   = ST_RUN;
            end
            ST_RUN: begin
                // Prefetched word arrives one cycle after its read enable.
                if (bit_cnt == '0 && div_cnt == DIV_W'(1)) begin
                    hold_n = mem_data;
                end
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    if (bit_cnt != BIT_LAST) begin
                        shift_n   = {shift[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end else if (word_addr == end_addr) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        shift_n     = hold;
                        word_addr_n = word_addr + ADDR_WIDTH'(1);
                        bit_cnt_n   = '0;
                    end
                end else begin
                    div_cnt_n = div_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Outputs are computed from next-cycle values so they line up with
        // the state they describe once registered.
        busy_n = (state_n != ST_IDLE);
        if (state_n == ST_RUN) begin
            audio_out_n = shift_n[DATA_WIDTH-1];
        end
        if (state_n == ST_PRIME) begin
            mem_ena_n  = 1'b1;
            mem_addr_n = '0;
        end else if (state_n == ST_RUN && bit_cnt_n == '0 && div_cnt_n == '0 &&
                     word_addr_n != end_addr_n) begin
            mem_ena_n  = 1'b1;
            mem_addr_n = word_addr_n + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_audio_playback_serializer.sv
// Testbench for audio_playback_serializer: random and directed playbacks
// checked cycle by cycle against a sample-stream reference model.
module tb_audio_playback_serializer;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned DIV = 4;
    localparam int          WORD_CYC = 16 * DIV;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          play = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] mem_data = '0;
    logic          mem_ena;
    logic [AW-1:0] mem_addr;
    logic          audio_out;
    logic          busy;
    logic          done;

    logic [15:0] mem [0:63];

    int n_cmp = 0;
    int n_err = 0;

    audio_playback_serializer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CLK_DIV    (DIV)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .play      (play),
        .last_addr (last_addr),
        .mem_data  (mem_data),
        .mem_ena   (mem_ena),
        .mem_addr  (mem_addr),
        .audio_out (audio_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM: data one cycle after the enable.
    always @(posedge clock) begin
        if (mem_ena) mem_data <= mem[mem_addr[5:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Plays words 0..last and checks every cycle. Optional actions (0 = off):
    // retrig_c re-raises play mid-playback, chg_c changes last_addr to 5,
    // abort_c asserts reset at that cycle.
    task automatic run_play(input int last, input int retrig_c, input int chg_c, input int abort_c);
        int  total;
        int  i;
        int  w;
        int  b;
        bit  aborted;
        logic busy_e, done_e, audio_e, ena_e;
        int  addr_e;
        total   = WORD_CYC * (last + 1);
        aborted = 1'b0;
        @(negedge clock);
        last_addr = AW'(last);
        play      = 1'b1;
        for (int c = 1; c <= total + 5; c++) begin
            @(negedge clock);
            if (aborted) begin
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_audio", 32'(audio_out), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_ena", 32'(mem_ena), 32'd0);
                check("abort_addr", 32'(mem_addr), 32'd0);
                reset = 1'b0;
                repeat (4) begin
                    @(negedge clock);
                    check("post_abort_busy", 32'(busy), 32'd0);
                    check("post_abort_done", 32'(done), 32'd0);
                    check("post_abort_ena", 32'(mem_ena), 32'd0);
                end
                break;
            end
            busy_e  = (c >= 1 && c <= total + 2);
            done_e  = (c == total + 3);
            audio_e = 1'b0;
            if (c >= 3 && c <= total + 2) begin
                i = c - 3;
                w = i / WORD_CYC;
                b = 15 - (i % WORD_CYC) / DIV;
                audio_e = mem[w][b];
            end
            ena_e  = 1'b0;
            addr_e = 0;
            if (c == 1) begin
                ena_e = 1'b1;
            end else if (c >= 3 && (c - 3) % WORD_CYC == 0 && (c - 3) / WORD_CYC < last) begin
                ena_e  = 1'b1;
                addr_e = (c - 3) / WORD_CYC + 1;
            end
            check("busy", 32'(busy), 32'(busy_e));
            check("done", 32'(done), 32'(done_e));
            check("audio", 32'(audio_out), 32'(audio_e));
            check("mem_ena", 32'(mem_ena), 32'(ena_e));
            if (ena_e) check("mem_addr", 32'(mem_addr), 32'(addr_e));
            if (c == 2) play = 1'b0;
            if (retrig_c > 0) begin
                if (c == retrig_c)      play = 1'b1;
                if (c == retrig_c + 10) play = 1'b0;
                if (c == retrig_c + 20) play = 1'b1;
            end
            if (chg_c > 0 && c == chg_c) last_addr = AW'(5);
            if (abort_c > 0 && c == abort_c) begin
                reset   = 1'b1;
                aborted = 1'b1;
            end
        end
        play = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 16'($urandom);

        // Reset with play toggling: outputs stay low.
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            play = ~play;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_audio", 32'(audio_out), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_ena", 32'(mem_ena), 32'd0);
            check("rst_addr", 32'(mem_addr), 32'd0);
        end
        // play high across reset release must not start playback.
        play = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("held_play_busy", 32'(busy), 32'd0);
            check("held_play_ena", 32'(mem_ena), 32'd0);
        end
        play = 1'b0;
        @(negedge clock);

        // Single word.
        mem[0] = 16'hA5C3;
        run_play(0, 0, 0, 0);

        // Three words, gap-free.
        mem[0] = 16'hFFFF;
        mem[1] = 16'h0000;
        mem[2] = 16'h8001;
        run_play(2, 0, 0, 0);

        // Re-trigger during playback is ignored.
        for (int k = 0; k < 4; k++) mem[k] = 16'($urandom);
        run_play(3, 40, 0, 0);

        // Reset during word 1, bit 7, then a fresh start from address 0.
        run_play(2, 0, 0, 3 + WORD_CYC + 8 * DIV + 1);
        run_play(1, 0, 0, 0);

        // last_addr change after the start edge has no effect.
        run_play(0, 0, 5, 0);

        // Random contents and lengths.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 8; k++) mem[k] = 16'($urandom);
            run_play(int'($urandom_range(0, 3)), 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audio_playback_serializer.md
# audio_playback_serializer

Playback-side counterpart of the microphone deserializer in the recorder datapath. On a rising edge of `play`, it reads 16-bit sample words from the recording block RAM, starting at address 0 and ending at a latched last address. Each word is shifted out MSB-first on the 1-bit `audio_out` line at a fixed bit rate of one bit every `CLK_DIV` system clocks. It sits between the memory block's read port and the audio output pin, and reports `busy` and `done` to the top-level control FSM.

## Interface
- `ADDR_WIDTH`, 16: width of the memory address and of `last_addr`.
- `DATA_WIDTH`, 16: sample word width. Fixed at 16; other values are unsupported.
- `CLK_DIV`, 50: system clocks per output bit. Legal values are 3 or more.

- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on `clock`.
- `play`  in  1  start request; acted on only on a 0→1 transition.
- `last_addr`  in  ADDR_WIDTH  final word address to play; latched on the start edge.
- `mem_data`  in  16  RAM read data; valid one cycle after `mem_ena`.
- `mem_ena`  out  1  RAM read enable, one-cycle pulse per word.
- `mem_addr`  out  ADDR_WIDTH  RAM read address.
- `audio_out`  out  1  serial sample stream, equal to `shift[15]` while busy, 0 otherwise.
- `busy`  out  1  high from the start edge until playback ends.
- `done`  out  1  one-cycle pulse when the last bit finishes.

## Operation
- **Start detection**
  - `play_q` is a registered copy of `play`.
  - A start is `play & ~play_q` while in IDLE.
  - Starts seen in any other state are ignored.
  - `play` already high when reset releases does not start playback; `play` must go low first.
- **States:** IDLE → PRIME → WAIT → RUN → IDLE.
- **IDLE**
  - Outputs are low.
  - On a start: latch `last_addr` into `end_addr`, set `word_addr` = 0, go to PRIME.
- **PRIME:** `mem_ena` = 1, `mem_addr` = 0 for one cycle. Go to WAIT.
- **WAIT:** on the cycle's end, load `shift` ← `mem_data`, clear `bit_cnt` and `div_cnt`, go to RUN.
- **RUN**
  - `div_cnt` counts 0..CLK_DIV-1.
  - At `div_cnt` = CLK_DIV-1 with `bit_cnt` < 15: shift `shift` left by 1 and increment `bit_cnt`.
  - At `div_cnt` = CLK_DIV-1 with `bit_cnt` = 15:
    - If `word_addr` == `end_addr`: go to IDLE and pulse `done`.
    - Otherwise: `shift` ← `hold`, `word_addr` += 1, `bit_cnt` ← 0.
- **Prefetch**
  - Applies in RUN when `bit_cnt` = 0, `div_cnt` = 0 and `word_addr` != `end_addr`.
  - That cycle: `mem_ena` = 1 and `mem_addr` = `word_addr` + 1.
  - `hold` ← `mem_data` at the end of the cycle with `div_cnt` = 1.
  - This gives gap-free word-to-word transitions.
- **Arithmetic**
  - Address increments are unsigned; the block stops before any wrap.
  - `end_addr` = 2^ADDR_WIDTH-1 is legal and plays the whole memory.
  - `last_addr` = 0 plays exactly one word.
- **Outside RUN:** `mem_addr` holds its last value, `mem_ena` = 0.
- **Reset** (in any state, including mid-word)
  - Next state is IDLE.
  - All counters, `shift` and `hold` clear.
  - `audio_out`, `busy`, `done` and `mem_ena` go to 0; `mem_addr` goes to 0.
  - No `done` pulse is issued for an aborted playback.
- Changes on `last_addr` after the start edge have no effect.

## Timing
- **Reset values:** `audio_out` = 0, `busy` = 0, `done` = 0, `mem_ena` = 0, `mem_addr` = 0.
- **Start sequence**, for a start edge sampled at cycle N:
  - cycle N+1: PRIME, `busy` = 1, `mem_ena` = 1.
  - cycle N+2: WAIT.
  - cycle N+3: first bit (word 0, bit 15) on `audio_out`.
- **Bit timing**
  - Each bit is held exactly CLK_DIV cycles.
  - There are no idle cycles between words.
- **Total duration:** the output is driven for 16·CLK_DIV·(end_addr+1) cycles.
- **End of playback**
  - `done` pulses for one cycle; `busy` and `audio_out` fall to 0 in that same cycle.
  - This is the cycle immediately after the last bit's final cycle.
- **Read latency:** `mem_data` is read exactly one cycle after `mem_ena`. No other latency is supported.
- **Back-to-back playback:** a new start is accepted from the cycle after `done`, given a fresh 0→1 on `play`.

## Test plan
- **Reset values:** hold `reset` 3 cycles with `play` toggling → all outputs 0 and no `mem_ena` pulses.
- **Single word:** CLK_DIV=4, mem[0]=16'hA5C3, last_addr=0, `play` pulse.
  - `mem_ena` once at addr 0.
  - `audio_out` = 1010_0101_1100_0011, each bit 4 cycles, starting at N+3.
  - `done` pulses at N+67; `busy` is high for exactly 66 cycles.
- **Three words:** CLK_DIV=4, mem[0..2] = 16'hFFFF, 16'h0000, 16'h8001, last_addr=2.
  - 192 contiguous bit-cycles with no gaps.
  - Prefetch `mem_ena` at addr 1 and addr 2 only.
  - `done` pulses once.
- **Re-trigger ignored:** drop and re-raise `play` mid-playback → no restart and `word_addr` continues.
  - `play` held high since before reset release → no start until it goes 0 then 1.
- **Reset mid-word:** assert `reset` during word 1, bit 7 → next cycle all outputs 0, no `done`.
  - A new `play` edge then restarts from addr 0.
- **Late `last_addr` change:** change `last_addr` 0→5 after the start edge → playback still ends after one word.
